// File: rtl/alu_issue.sv
// Operand-fetch/writeback stage for the SM83 ALU; owns A,F,B,C,D,E,H,L. Optional trace: ALU_ISSUE_TRACE_EN.
// Latency: register op 1 cycle after accept, ADD HL,rr 2 cycles, (HL) ops add memory wait cycles.
// Backpressure: uop_ready is high only in IDLE; mem_req is held until mem_ack.
module alu_issue #(
    parameter logic [15:0] RESET_AF = 16'h01B0,
    parameter logic [15:0] RESET_BC = 16'h0013,
    parameter logic [15:0] RESET_DE = 16'h00D8,
    parameter logic [15:0] RESET_HL = 16'h014D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uop_valid,
    output logic        uop_ready,
    input  logic [3:0]  uop_op,
    input  logic [2:0]  uop_src,
    input  logic        uop_imm_en,
    input  logic [7:0]  uop_imm,
    input  logic        uop_wide,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_lhs,
    output logic [7:0]  alu_rhs,
    output logic [3:0]  alu_flags,
    input  logic [7:0]  alu_r,
    input  logic [3:0]  alu_fout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] dbg_af,
    output logic [15:0] dbg_bc,
    output logic [15:0] dbg_de,
    output logic [15:0] dbg_hl
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_RD,
        S_EXEC,
        S_EXEC_HI,
        S_MEM_WR
    } state_t;

    state_t      state;
    logic [7:0]  a, f, b, c, d, e, h, l;
    logic [3:0]  op_q;
    logic [2:0]  src_q;
    logic        imm_en_q;
    logic [7:0]  imm_q;
    logic        wide_q;
    logic [7:0]  mdata_q;
    logic        carry_q;

    logic [7:0]  src_val;
    logic [7:0]  rr_lo;
    logic [7:0]  rr_hi;

    always_comb begin
        src_val = 8'h00;
        case (src_q)
            3'd0: src_val = b;
            3'd1: src_val = c;
            3'd2: src_val = d;
            3'd3: src_val = e;
            3'd4: src_val = h;
            3'd5: src_val = l;
            3'd6: src_val = mdata_q;
            default: src_val = a;
        endcase
    end

    always_comb begin
        rr_lo = l;
        rr_hi = h;
        case (src_q[2:1])
            2'd0: begin rr_lo = c; rr_hi = b; end
            2'd1: begin rr_lo = e; rr_hi = d; end
            default: begin rr_lo = l; rr_hi = h; end
        endcase
    end

    // ALU drive is a pure decode of the registered state and latched micro-op.
    always_comb begin
        alu_op    = 4'd0;
        alu_lhs   = 8'h00;
        alu_rhs   = 8'h00;
        alu_flags = f[7:4];
        if (state == S_EXEC) begin
            if (wide_q) begin
                alu_lhs = l;
                alu_rhs = rr_lo;
            end else begin
                alu_op  = op_q;
                alu_lhs = op_q[3] ? 8'h00 : a;
                alu_rhs = imm_en_q ? imm_q : src_val;
            end
        end else if (state == S_EXEC_HI) begin
            alu_op    = 4'd1;
            alu_lhs   = h;
            alu_rhs   = rr_hi;
            alu_flags = {f[7:5], carry_q};
        end
    end

    assign mem_addr = {h, l};
    assign dbg_af   = {a, f};
    assign dbg_bc   = {b, c};
    assign dbg_de   = {d, e};
    assign dbg_hl   = {h, l};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            uop_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            a         <= RESET_AF[15:8];
            f         <= {RESET_AF[7:4], 4'h0};
            b         <= RESET_BC[15:8];
            c         <= RESET_BC[7:0];
            d         <= RESET_DE[15:8];
            e         <= RESET_DE[7:0];
            h         <= RESET_HL[15:8];
            l         <= RESET_HL[7:0];
            op_q      <= 4'd0;
            src_q     <= 3'd0;
            imm_en_q  <= 1'b0;
            imm_q     <= 8'h00;
            wide_q    <= 1'b0;
            mdata_q   <= 8'h00;
            carry_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (uop_valid) begin
                        op_q      <= uop_op;
                        src_q     <= uop_src;
                        // Rotates/shifts always act on the src location, never an immediate.
                        imm_en_q  <= uop_imm_en & ~uop_op[3];
                        imm_q     <= uop_imm;
                        wide_q    <= uop_wide;
                        uop_ready <= 1'b0;
                        if (uop_src == 3'd6 && !(uop_imm_en && !uop_op[3]) && !uop_wide) begin
                            state   <= S_MEM_RD;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_MEM_RD: begin
                    if (mem_ack) begin
                        mdata_q <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (wide_q) begin
                        l       <= alu_r;
                        carry_q <= alu_fout[0];
                        state   <= S_EXEC_HI;
                    end else begin
                        f <= {alu_fout, 4'h0};
                        if (op_q[3] && src_q == 3'd6) begin
                            mem_wdata <= alu_r;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            state     <= S_MEM_WR;
                        end else begin
                            if (op_q[3]) begin
                                case (src_q)
                                    3'd0: b <= alu_r;
                                    3'd1: c <= alu_r;
                                    3'd2: d <= alu_r;
                                    3'd3: e <= alu_r;
                                    3'd4: h <= alu_r;
                                    3'd5: l <= alu_r;
                                    3'd7: a <= alu_r;
                                    default: ;
                                endcase
                            end else if (op_q != 4'd7) begin
                                a <= alu_r;
                            end
                            state     <= S_IDLE;
                            uop_ready <= 1'b1;
                        end
                    end
                end
                S_EXEC_HI: begin
                    h         <= alu_r;
                    f         <= {f[7], 1'b0, alu_fout[1:0], 4'h0};
                    state     <= S_IDLE;
                    uop_ready <= 1'b1;
                end
                S_MEM_WR: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state     <= S_IDLE;
                        uop_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    uop_ready <= 1'b1;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            if ((state == S_EXEC && !(op_q[3] && src_q == 3'd6 && !wide_q)) || state == S_EXEC_HI)
                $display("ALU op=%h src=%h r=%h f=%h", alu_op, src_q, alu_r, alu_fout);
            else if (state == S_MEM_WR && mem_ack)
                $display("ALU op=%h src=%h r=%h f=%h", op_q, src_q, mem_wdata, f[7:4]);
        end
    end
`else
    // Untraced build: writebacks are silent.
`endif

endmodule
